// File: rtl/rs_alu_pool_pkg.sv
// Shared types and constants for the ALU reservation station.
package rs_alu_pool_pkg;

  typedef logic [31:0] word_t;

  // Source tag value meaning "operand already holds its data".
  localparam int UNLOCKED = 0;

  localparam int WORD_W = 32;

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the ready entry with the largest age. Busy ages are distinct, so the
// strict compare only breaks ties for stale non-busy entries, which are never ready.
module rs_oldest_select #(
  parameter int DEPTH = 4,
  parameter int AGE_W = 2
) (
  input  logic [DEPTH-1:0]       ready,
  input  logic [DEPTH*AGE_W-1:0] ages,
  output logic [DEPTH-1:0]       grant,
  output logic                   any
);

  logic [AGE_W-1:0] best_age;

  // Linear scan keeping the oldest ready candidate seen so far.
  always_comb begin
    grant    = '0;
    any      = 1'b0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!any || ages[i*AGE_W +: AGE_W] > best_age)) begin
        any      = 1'b1;
        best_age = ages[i*AGE_W +: AGE_W];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu_pool.sv
// ALU reservation station: DEPTH entries, N_CDB-bus wake-up, oldest-ready issue.
module rs_alu_pool
  import rs_alu_pool_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int N_CDB = 3,
  parameter int TAG_W = 4,
  parameter int OP_W  = 6,
  parameter int REG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [31:0]              alloc_pc,
  input  logic [OP_W-1:0]          alloc_op,
  input  logic [TAG_W-1:0]         alloc_tagx,
  input  logic [TAG_W-1:0]         alloc_tagy,
  input  logic [31:0]              alloc_datax,
  input  logic [31:0]              alloc_datay,
  input  logic [TAG_W-1:0]         alloc_tagw,
  input  logic [REG_W-1:0]         alloc_addrw,
  input  logic [N_CDB-1:0]         cdb_valid,
  input  logic [N_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [N_CDB*32-1:0]      cdb_data,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [31:0]              issue_pc,
  output logic [OP_W-1:0]          issue_op,
  output logic [31:0]              issue_datax,
  output logic [31:0]              issue_datay,
  output logic [TAG_W-1:0]         issue_tagw,
  output logic [REG_W-1:0]         issue_addrw,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AGE_W = $clog2(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [TAG_W-1:0] TAG_UNLOCKED = TAG_W'(UNLOCKED);
  localparam logic [AGE_W-1:0] AGE_MAX      = AGE_W'(DEPTH-1);

  logic [DEPTH-1:0] busy;
  word_t            e_pc    [DEPTH];
  logic [OP_W-1:0]  e_op    [DEPTH];
  logic [TAG_W-1:0] e_tagx  [DEPTH];
  logic [TAG_W-1:0] e_tagy  [DEPTH];
  word_t            e_datax [DEPTH];
  word_t            e_datay [DEPTH];
  logic [TAG_W-1:0] e_tagw  [DEPTH];
  logic [REG_W-1:0] e_addrw [DEPTH];
  logic [AGE_W-1:0] e_age   [DEPTH];

  logic [TAG_W-1:0] nx_tagx  [DEPTH];
  logic [TAG_W-1:0] nx_tagy  [DEPTH];
  word_t            nx_datax [DEPTH];
  word_t            nx_datay [DEPTH];

  logic [DEPTH-1:0]       ready_vec, arb_grant, sel_grant, hold_grant;
  logic [DEPTH*AGE_W-1:0] age_flat;
  logic                   arb_any, sel_any, hold_valid;
  logic [AGE_W-1:0]       sel_age;
  logic [IDX_W-1:0]       free_idx;
  logic                   free_found, alloc_fire, issue_fire;
  logic [TAG_W-1:0]       ax_tag, ay_tag;
  word_t                  ax_data, ay_data;

  // Ready bits and flattened ages from registered state only.
  always_comb begin
    ready_vec = '0;
    age_flat  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = busy[i] && e_tagx[i] == TAG_UNLOCKED && e_tagy[i] == TAG_UNLOCKED;
      age_flat[i*AGE_W +: AGE_W] = e_age[i];
    end
  end

  rs_oldest_select #(.DEPTH(DEPTH), .AGE_W(AGE_W)) u_select (
    .ready (ready_vec),
    .ages  (age_flat),
    .grant (arb_grant),
    .any   (arb_any)
  );

  // A stalled offer stays pinned so an older entry waking later cannot overtake it.
  assign sel_grant   = hold_valid ? hold_grant : arb_grant;
  assign sel_any     = hold_valid ? 1'b1 : arb_any;
  assign issue_valid = sel_any && rdy && !flush;
  assign issue_fire  = issue_valid && issue_ready;

  // One-hot mux of the selected entry onto the issue port.
  always_comb begin
    issue_pc    = '0;
    issue_op    = '0;
    issue_datax = '0;
    issue_datay = '0;
    issue_tagw  = '0;
    issue_addrw = '0;
    sel_age     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_grant[i]) begin
        issue_pc    = e_pc[i];
        issue_op    = e_op[i];
        issue_datax = e_datax[i];
        issue_datay = e_datay[i];
        issue_tagw  = e_tagw[i];
        issue_addrw = e_addrw[i];
        sel_age     = e_age[i];
      end
    end
  end

  // Lowest-index free slot, judged from pre-edge occupancy.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign alloc_ready = free_found && rdy && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Operand wake-up for stored entries; scanning downward lets the lowest bus win.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nx_tagx[i]  = e_tagx[i];
      nx_datax[i] = e_datax[i];
      nx_tagy[i]  = e_tagy[i];
      nx_datay[i] = e_datay[i];
      for (int b = N_CDB-1; b >= 0; b--) begin
        if (cdb_valid[b] && e_tagx[i] != TAG_UNLOCKED && cdb_tag[b*TAG_W +: TAG_W] == e_tagx[i]) begin
          nx_tagx[i]  = TAG_UNLOCKED;
          nx_datax[i] = cdb_data[b*32 +: 32];
        end
        if (cdb_valid[b] && e_tagy[i] != TAG_UNLOCKED && cdb_tag[b*TAG_W +: TAG_W] == e_tagy[i]) begin
          nx_tagy[i]  = TAG_UNLOCKED;
          nx_datay[i] = cdb_data[b*32 +: 32];
        end
      end
    end
  end

  // Same-cycle bypass for the incoming op's sources.
  always_comb begin
    ax_tag  = alloc_tagx;
    ax_data = alloc_datax;
    ay_tag  = alloc_tagy;
    ay_data = alloc_datay;
    for (int b = N_CDB-1; b >= 0; b--) begin
      if (cdb_valid[b] && alloc_tagx != TAG_UNLOCKED && cdb_tag[b*TAG_W +: TAG_W] == alloc_tagx) begin
        ax_tag  = TAG_UNLOCKED;
        ax_data = cdb_data[b*32 +: 32];
      end
      if (cdb_valid[b] && alloc_tagy != TAG_UNLOCKED && cdb_tag[b*TAG_W +: TAG_W] == alloc_tagy) begin
        ay_tag  = TAG_UNLOCKED;
        ay_data = cdb_data[b*32 +: 32];
      end
    end
  end

  // Entry array, ages, occupancy count and issue hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      count      <= '0;
      hold_valid <= 1'b0;
      hold_grant <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_pc[i]    <= '0;
        e_op[i]    <= '0;
        e_tagx[i]  <= TAG_UNLOCKED;
        e_tagy[i]  <= TAG_UNLOCKED;
        e_datax[i] <= '0;
        e_datay[i] <= '0;
        e_tagw[i]  <= '0;
        e_addrw[i] <= '0;
        e_age[i]   <= '0;
      end
    end else if (flush) begin
      busy       <= '0;
      count      <= '0;
      hold_valid <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i]) begin
          logic [AGE_W-1:0] age_n;
          age_n = e_age[i];
          if (issue_fire && e_age[i] > sel_age) age_n = age_n - 1'b1;
          if (alloc_fire && age_n != AGE_MAX)   age_n = age_n + 1'b1;
          e_age[i]   <= age_n;
          e_tagx[i]  <= nx_tagx[i];
          e_tagy[i]  <= nx_tagy[i];
          e_datax[i] <= nx_datax[i];
          e_datay[i] <= nx_datay[i];
          if (issue_fire && sel_grant[i]) busy[i] <= 1'b0;
        end
      end
      if (alloc_fire) begin
        busy[free_idx]    <= 1'b1;
        e_pc[free_idx]    <= alloc_pc;
        e_op[free_idx]    <= alloc_op;
        e_tagx[free_idx]  <= ax_tag;
        e_tagy[free_idx]  <= ay_tag;
        e_datax[free_idx] <= ax_data;
        e_datay[free_idx] <= ay_data;
        e_tagw[free_idx]  <= alloc_tagw;
        e_addrw[free_idx] <= alloc_addrw;
        e_age[free_idx]   <= '0;
      end
      count      <= count + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
      hold_valid <= issue_valid && !issue_ready;
      hold_grant <= sel_grant;
    end
  end

endmodule

// File: tb/tb_rs_alu_pool.sv
// Directed bench for rs_alu_pool with immediate-assertion checks.
module tb_rs_alu_pool;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        alloc_valid, alloc_ready;
  logic [31:0] alloc_pc, alloc_datax, alloc_datay;
  logic [5:0]  alloc_op;
  logic [3:0]  alloc_tagx, alloc_tagy, alloc_tagw;
  logic [4:0]  alloc_addrw;
  logic [2:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [95:0] cdb_data;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_pc, issue_datax, issue_datay;
  logic [5:0]  issue_op;
  logic [3:0]  issue_tagw;
  logic [4:0]  issue_addrw;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  rs_alu_pool #(.DEPTH(4), .N_CDB(3), .TAG_W(4), .OP_W(6), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pc(alloc_pc), .alloc_op(alloc_op),
    .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy),
    .alloc_datax(alloc_datax), .alloc_datay(alloc_datay),
    .alloc_tagw(alloc_tagw), .alloc_addrw(alloc_addrw),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pc(issue_pc), .issue_op(issue_op),
    .issue_datax(issue_datax), .issue_datay(issue_datay),
    .issue_tagw(issue_tagw), .issue_addrw(issue_addrw),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic [3:0] tx, input logic [31:0] dx,
                          input logic [3:0] ty, input logic [31:0] dy);
    alloc_valid = 1'b1;
    alloc_pc    = pc;
    alloc_tagx  = tx;
    alloc_datax = dx;
    alloc_tagy  = ty;
    alloc_datay = dy;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; issue_ready = 1'b1;
    alloc_valid = 1'b0; alloc_pc = '0; alloc_op = 6'd1;
    alloc_tagx = '0; alloc_tagy = '0; alloc_datax = '0; alloc_datay = '0;
    alloc_tagw = 4'd1; alloc_addrw = 5'd3;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_issue_pc", issue_pc, 0);

    // 1: both operands ready
    do_alloc(32'h100, 4'd0, 32'd5, 4'd0, 32'd7);
    #1 chk("t1_alloc_ready", alloc_ready, 1);
    step(); alloc_valid = 1'b0; #1;
    chk("t1_issue_valid", issue_valid, 1);
    chk("t1_datax", issue_datax, 5);
    chk("t1_datay", issue_datay, 7);
    chk("t1_op", issue_op, 1);
    chk("t1_tagw", issue_tagw, 1);
    chk("t1_addrw", issue_addrw, 3);
    chk("t1_count", count, 1);
    step();
    chk("t1_count_after", count, 0);
    chk("t1_valid_after", issue_valid, 0);

    // 2: wake-up two cycles after alloc
    do_alloc(32'h110, 4'd3, 32'd0, 4'd0, 32'h22);
    step(); alloc_valid = 1'b0; #1;
    chk("t2_locked", issue_valid, 0);
    chk("t2_count", count, 1);
    step();
    cdb_valid = 3'b001; cdb_tag = {4'd0, 4'd0, 4'd3}; cdb_data = {32'd0, 32'd0, 32'h1234};
    #1 chk("t2_not_same_cycle", issue_valid, 0);
    step(); cdb_valid = '0; #1;
    chk("t2_woken", issue_valid, 1);
    chk("t2_datax", issue_datax, 32'h1234);
    chk("t2_datay", issue_datay, 32'h22);
    step();
    chk("t2_count_after", count, 0);

    // 3: fill, full, broadcast wake, issue in alloc order
    for (int i = 0; i < 4; i++) begin
      do_alloc(32'h200 + 32'(4*i), 4'd2, 32'd0, 4'd0, 32'(i));
      #1 chk("t3_fill_ready", alloc_ready, 1);
      step();
    end
    do_alloc(32'h2F0, 4'd0, 32'd0, 4'd0, 32'd0);
    #1;
    chk("t3_full_count", count, 4);
    chk("t3_full_alloc_ready", alloc_ready, 0);
    chk("t3_full_issue_valid", issue_valid, 0);
    cdb_valid = 3'b010; cdb_tag = {4'd0, 4'd2, 4'd0}; cdb_data = {32'd0, 32'hAA, 32'd0};
    step(); alloc_valid = 1'b0; cdb_valid = '0; #1;
    chk("t3_dropped_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order_valid", issue_valid, 1);
      chk("t3_order_pc", issue_pc, 32'h200 + 32'(4*i));
      chk("t3_order_datax", issue_datax, 32'hAA);
      step();
    end
    chk("t3_empty", count, 0);

    // 4: same-cycle bypass, bus 2 matches
    do_alloc(32'h120, 4'd0, 32'd3, 4'd5, 32'd0);
    cdb_valid = 3'b101; cdb_tag = {4'd5, 4'd0, 4'd6}; cdb_data = {32'd9, 32'd0, 32'hDEAD};
    step(); alloc_valid = 1'b0; cdb_valid = '0; #1;
    chk("t4_valid", issue_valid, 1);
    chk("t4_datay", issue_datay, 9);
    chk("t4_datax", issue_datax, 3);
    step();
    chk("t4_count_after", count, 0);

    // 5a: stall with younger entry waking
    issue_ready = 1'b0;
    do_alloc(32'h400, 4'd0, 32'h40, 4'd0, 32'h41);
    step();
    do_alloc(32'h404, 4'd8, 32'd0, 4'd0, 32'd0);
    #1 chk("t5a_first_pc", issue_pc, 32'h400);
    step(); alloc_valid = 1'b0;
    cdb_valid = 3'b010; cdb_tag = {4'd0, 4'd8, 4'd0}; cdb_data = {32'd0, 32'h88, 32'd0};
    step(); cdb_valid = '0;
    for (int k = 0; k < 3; k++) begin
      chk("t5a_stable_valid", issue_valid, 1);
      chk("t5a_stable_pc", issue_pc, 32'h400);
      chk("t5a_stable_datax", issue_datax, 32'h40);
      if (k < 2) step();
    end
    issue_ready = 1'b1;
    step();
    chk("t5a_second_pc", issue_pc, 32'h404);
    chk("t5a_second_datax", issue_datax, 32'h88);
    step();
    chk("t5a_count_after", count, 0);

    // 5b: older entry waking during a stall must not overtake
    issue_ready = 1'b0;
    do_alloc(32'h300, 4'd7, 32'd0, 4'd0, 32'd0);
    step();
    do_alloc(32'h304, 4'd0, 32'd1, 4'd0, 32'd2);
    step(); alloc_valid = 1'b0; #1;
    chk("t5b_young_valid", issue_valid, 1);
    chk("t5b_young_pc", issue_pc, 32'h304);
    cdb_valid = 3'b001; cdb_tag = {4'd0, 4'd0, 4'd7}; cdb_data = {32'd0, 32'd0, 32'h77};
    step(); cdb_valid = '0;
    chk("t5b_no_overtake", issue_pc, 32'h304);
    step();
    chk("t5b_no_overtake2", issue_pc, 32'h304);
    issue_ready = 1'b1;
    step();
    chk("t5b_old_pc", issue_pc, 32'h300);
    chk("t5b_old_datax", issue_datax, 32'h77);
    step();
    chk("t5b_count_after", count, 0);

    // 6: rdy freeze, then flush with alloc offered
    issue_ready = 1'b0;
    do_alloc(32'h500, 4'd0, 32'd1, 4'd0, 32'd2);
    step();
    do_alloc(32'h504, 4'd9, 32'd0, 4'd0, 32'd0);
    step();
    do_alloc(32'h508, 4'd9, 32'd0, 4'd0, 32'd0);
    step(); alloc_valid = 1'b0; #1;
    chk("t6_count3", count, 3);
    chk("t6_pc", issue_pc, 32'h500);
    rdy = 1'b0;
    do_alloc(32'h50C, 4'd0, 32'd0, 4'd0, 32'd0);
    cdb_valid = 3'b001; cdb_tag = {4'd0, 4'd0, 4'd9}; cdb_data = {32'd0, 32'd0, 32'h99};
    #1;
    chk("t6_stall_alloc_ready", alloc_ready, 0);
    chk("t6_stall_issue_valid", issue_valid, 0);
    step(); step();
    rdy = 1'b1; alloc_valid = 1'b0; cdb_valid = '0; #1;
    chk("t6_frozen_count", count, 3);
    chk("t6_frozen_valid", issue_valid, 1);
    chk("t6_frozen_pc", issue_pc, 32'h500);
    flush = 1'b1;
    do_alloc(32'h510, 4'd0, 32'd0, 4'd0, 32'd0);
    #1;
    chk("t6_flush_alloc_ready", alloc_ready, 0);
    chk("t6_flush_issue_valid", issue_valid, 0);
    step(); flush = 1'b0; alloc_valid = 1'b0; #1;
    chk("t6_flush_count", count, 0);
    chk("t6_flush_valid", issue_valid, 0);
    chk("t6_flush_alloc_ready_after", alloc_ready, 1);
    issue_ready = 1'b1;
    do_alloc(32'h520, 4'd0, 32'hA, 4'd0, 32'hB);
    step(); alloc_valid = 1'b0; #1;
    chk("t6_post_valid", issue_valid, 1);
    chk("t6_post_pc", issue_pc, 32'h520);
    step();
    chk("t6_post_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
